// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive control block.
package uart_rx_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_frame_e;

    // Start + 8 data + stop: a frame that runs this long without a byte is a false start.
    localparam int unsigned FRAME_BITS = 10;
    localparam logic [15:0] MIN_DIV    = 16'd4;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-facing and read-side signals of uart_rx_ctrl; master drives, slave is the controller.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rx_sbit_i;
    logic          rx_dv_i;
    logic [7:0]    rx_byte_i;
    logic [15:0]   clks_per_bit_o;
    logic          rd_i;
    logic [7:0]    rd_data_o;
    logic          rd_valid_o;
    logic [LW-1:0] level_o;

    modport master (
        output rx_sbit_i, rx_dv_i, rx_byte_i, rd_i,
        input  clks_per_bit_o, rd_data_o, rd_valid_o, level_o
    );

    modport slave (
        input  rx_sbit_i, rx_dv_i, rx_byte_i, rd_i,
        output clks_per_bit_o, rd_data_o, rd_valid_o, level_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO: head is read combinationally, flush beats push/pop.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wr_data_i,
    output logic [7:0]    rd_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [LW-1:0] level_reg;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (level_reg == '0);
    assign full_o  = (level_reg == LW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[tail_reg] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            level_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop_ok) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_data_o = mem[head_reg];
    assign level_o   = level_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame tracking, deferred divisor updates, RX FIFO and interrupts.
// Build option: define UART_RX_TIMEOUT_EN to include the idle-timeout counter and tout_o.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int RESET_DIV = 87,
    parameter  int TOUT_BITS = 32,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic [15:0]   div_i,
    input  logic          div_we_i,
    uart_rx_ctrl_if.slave bus,
    input  logic [LW-1:0] wm_i,
    output logic          ovf_o,
    input  logic          ovf_clr_i,
    output logic          tout_o,
    output logic          irq_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TOUT_BITS < 1 || RESET_DIV < int'(MIN_DIV)) begin : g_bad_cfg
        $error("uart_rx_ctrl: illegal parameter combination");
    end

    rx_frame_e     state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [15:0]   cyc_cnt_reg;
    logic [15:0]   div_reg;
    logic [15:0]   div_pend_reg;
    logic          div_pend_vld_reg;
    logic          ovf_reg;
    logic          tout_reg;
    logic          irq_reg;

    logic [15:0]   div_last;
    logic          push_req;
    logic          pop_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] level;
    logic          ovf_evt;
    logic          wm_hit;

    assign div_last = div_reg - 16'd1;
    assign push_req = bus.rx_dv_i & en_i;
    assign pop_req  = bus.rd_i & ~fifo_empty;
    // Byte lost only when nothing frees a slot and flush is not already discarding it.
    assign ovf_evt  = push_req & fifo_full & ~pop_req & ~flush_i;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .push_i    (push_req),
        .pop_i     (bus.rd_i),
        .wr_data_i (bus.rx_byte_i),
        .rd_data_o (bus.rd_data_o),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            cyc_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rx_sbit_i) begin
                        state_reg   <= ST_FRAME;
                        bit_cnt_reg <= '0;
                        cyc_cnt_reg <= '0;
                    end
                end
                ST_FRAME: begin
                    if (bus.rx_dv_i) begin
                        state_reg <= ST_IDLE;
                    end else if (cyc_cnt_reg == div_last) begin
                        cyc_cnt_reg <= '0;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The divisor may only move between frames; a write in the apply cycle stays pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_reg          <= 16'(RESET_DIV);
            div_pend_reg     <= '0;
            div_pend_vld_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && !bus.rx_sbit_i && div_pend_vld_reg) begin
                div_reg          <= div_pend_reg;
                div_pend_vld_reg <= 1'b0;
            end
            if (div_we_i) begin
                div_pend_reg     <= clamp_div(div_i);
                div_pend_vld_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_reg <= 1'b0;
        end else if (ovf_evt) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_reg <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TBW = $clog2(TOUT_BITS + 1);
    localparam logic [TBW-1:0] TOUT_MAX = TBW'(TOUT_BITS);

    logic [15:0]    tout_cyc_reg;
    logic [TBW-1:0] tout_bits_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tout_cyc_reg  <= '0;
            tout_bits_reg <= '0;
            tout_reg      <= 1'b0;
        end else if (flush_i || push_req || pop_req) begin
            tout_cyc_reg  <= '0;
            tout_bits_reg <= '0;
            if (flush_i || pop_req) begin
                tout_reg <= 1'b0;
            end
        end else if (!fifo_empty && state_reg == ST_IDLE && tout_bits_reg != TOUT_MAX) begin
            if (tout_cyc_reg == div_last) begin
                tout_cyc_reg  <= '0;
                tout_bits_reg <= tout_bits_reg + 1'b1;
                if (tout_bits_reg == TOUT_MAX - 1'b1) begin
                    tout_reg <= 1'b1;
                end
            end else begin
                tout_cyc_reg <= tout_cyc_reg + 16'd1;
            end
        end
    end
`else
    assign tout_reg = 1'b0;
`endif

    assign wm_hit = (wm_i != '0) && (level >= wm_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= wm_hit | ovf_reg | tout_reg;
        end
    end

    assign bus.clks_per_bit_o = div_reg;
    assign bus.rd_valid_o     = ~fifo_empty;
    assign bus.level_o        = level;
    assign ovf_o              = ovf_reg;
    assign tout_o             = tout_reg;
    assign irq_o              = irq_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (both UART_RX_TIMEOUT_EN builds).
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_TIMEOUT_EN
    localparam logic TOUT_ON = 1'b1;
`else
    localparam logic TOUT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic [15:0]   div;
    logic          div_we;
    logic [LW-1:0] wm;
    logic          ovf;
    logic          ovf_clr;
    logic          tout;
    logic          irq;

    int total = 0;
    int bad   = 0;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(
        .DEPTH     (DEPTH),
        .RESET_DIV (87),
        .TOUT_BITS (32)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .flush_i   (flush),
        .div_i     (div),
        .div_we_i  (div_we),
        .bus       (bus),
        .wm_i      (wm),
        .ovf_o     (ovf),
        .ovf_clr_i (ovf_clr),
        .tout_o    (tout),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
        $display("check %-14s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_dv_i   = 1'b1;
        bus.rx_byte_i = b;
        tick();
        bus.rx_dv_i   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
    endtask

    task automatic write_div(input logic [15:0] d);
        div    = d;
        div_we = 1'b1;
        tick();
        div_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; div = '0; div_we = 1'b0;
        wm = '0; ovf_clr = 1'b0;
        bus.rx_sbit_i = 1'b0; bus.rx_dv_i = 1'b0; bus.rx_byte_i = '0; bus.rd_i = 1'b0;
        tick(3);

        // Reset values
        check("rst_div",   32'(bus.clks_per_bit_o), 32'd87);
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_ovf",   32'(ovf), 32'd0);
        check("rst_tout",  32'(tout), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        rst = 1'b0;
        tick();

        // Idle divisor apply and clamp
        write_div(16'h0010);
        tick();
        check("div_idle", 32'(bus.clks_per_bit_o), 32'h10);
        write_div(16'h0002);
        tick();
        check("div_clamp", 32'(bus.clks_per_bit_o), 32'h4);

        // False start: 10 bit-times of 4 clocks end the frame, then the pending divisor applies
        bus.rx_sbit_i = 1'b1;
        tick();
        bus.rx_sbit_i = 1'b0;
        write_div(16'h0010);
        tick(30);
        check("guard_hold", 32'(bus.clks_per_bit_o), 32'h4);
        tick(20);
        check("guard_apply", 32'(bus.clks_per_bit_o), 32'h10);

        // Deferred apply: frame ends on rx_dv, divisor moves one edge later
        bus.rx_sbit_i = 1'b1;
        tick();
        bus.rx_sbit_i = 1'b0;
        write_div(16'h0020);
        tick(5);
        check("defer_mid", 32'(bus.clks_per_bit_o), 32'h10);
        push(8'hA5);
        check("defer_dv", 32'(bus.clks_per_bit_o), 32'h10);
        check("fwft_level", 32'(bus.level_o), 32'd1);
        check("fwft_data", 32'(bus.rd_data_o), 32'hA5);
        tick();
        check("defer_apply", 32'(bus.clks_per_bit_o), 32'h20);
        flush = 1'b1; tick(); flush = 1'b0;

        // Reset mid-frame drops the pending divisor
        bus.rx_sbit_i = 1'b1;
        tick();
        bus.rx_sbit_i = 1'b0;
        write_div(16'h0030);
        rst = 1'b1;
        tick();
        check("midrst_div", 32'(bus.clks_per_bit_o), 32'd87);
        rst = 1'b0;
        tick(3);
        check("midrst_pend", 32'(bus.clks_per_bit_o), 32'd87);

        // Disabled receive and read on empty are ignored
        en = 1'b0;
        push(8'h55);
        check("en_off", 32'(bus.level_o), 32'd0);
        en = 1'b1;
        pop();
        check("rd_empty", 32'(bus.level_o), 32'd0);
        check("rd_empty_v", 32'(bus.rd_valid_o), 32'd0);

        // Overrun: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) push(8'(i));
        check("ovr_level", 32'(bus.level_o), 32'd16);
        check("ovr_ovf", 32'(ovf), 32'd1);
        tick();
        check("ovr_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_rd%0d", i), 32'(bus.rd_data_o), 32'(i));
            pop();
        end
        check("ovr_drained", 32'(bus.rd_valid_o), 32'd0);
        check("ovr_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        tick();
        check("irq_clr", 32'(irq), 32'd0);

        // Full FIFO with push and pop together
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        bus.rx_dv_i = 1'b1; bus.rx_byte_i = 8'h50; bus.rd_i = 1'b1;
        tick();
        bus.rx_dv_i = 1'b0; bus.rd_i = 1'b0;
        check("pp_level", 32'(bus.level_o), 32'd16);
        check("pp_ovf", 32'(ovf), 32'd0);
        check("pp_head", 32'(bus.rd_data_o), 32'h41);
        // Overrun coinciding with clear: set wins
        bus.rx_dv_i = 1'b1; bus.rx_byte_i = 8'h51; ovf_clr = 1'b1;
        tick();
        bus.rx_dv_i = 1'b0; ovf_clr = 1'b0;
        check("ovf_setwin", 32'(ovf), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_level", 32'(bus.level_o), 32'd0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tick();

        // Watermark, then flush beating a same-cycle push
        wm = LW'(4);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        check("wm_level", 32'(bus.level_o), 32'd4);
        check("wm_irq_lag", 32'(irq), 32'd0);
        tick();
        check("wm_irq", 32'(irq), 32'd1);
        flush = 1'b1; bus.rx_dv_i = 1'b1; bus.rx_byte_i = 8'hEE;
        tick();
        flush = 1'b0; bus.rx_dv_i = 1'b0;
        check("flush_push", 32'(bus.level_o), 32'd0);
        tick();
        check("flush_irq", 32'(irq), 32'd0);
        wm = '0;

        // Idle timeout: 32 bit-times of 8 clocks = 256 idle cycles after the push
        write_div(16'h0008);
        tick();
        check("tout_div", 32'(bus.clks_per_bit_o), 32'h8);
        push(8'h77);
        tick(255);
        check("tout_early", 32'(tout), 32'd0);
        tick();
        check("tout_set", 32'(tout), 32'(TOUT_ON));
        tick();
        check("tout_irq", 32'(irq), 32'(TOUT_ON));
        check("tout_data", 32'(bus.rd_data_o), 32'h77);
        pop();
        check("tout_popclr", 32'(tout), 32'd0);
        check("tout_empty", 32'(bus.level_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block for the UART receiver. It drives the receiver's `CLKS_PER_BIT` divisor and applies divisor updates only between frames. Received bytes go into a first-word-fall-through FIFO. It raises watermark, overrun and idle-timeout interrupts toward the peripheral register file.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `RESET_DIV`, 87: divisor after reset.
- `TOUT_BITS`, 32: idle bit-times before timeout.

Ports:
- `clk_i`  in  1  clock; only clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `en_i`  in  1  receive enable; when low, `rx_dv_i` is ignored.
- `flush_i`  in  1  empty FIFO, clear timeout.
- `div_i`  in  16  requested divisor.
- `div_we_i`  in  1  capture `div_i` as pending divisor.
- `clks_per_bit_o`  out  16  divisor to receiver.
- `rx_sbit_i`  in  1  receiver start-bit flag.
- `rx_dv_i`  in  1  receiver byte-valid pulse.
- `rx_byte_i`  in  8  received byte.
- `rd_i`  in  1  pop FIFO head.
- `rd_data_o`  out  8  FIFO head.
- `rd_valid_o`  out  1  FIFO non-empty.
- `level_o`  out  $clog2(DEPTH)+1  entries held.
- `wm_i`  in  $clog2(DEPTH)+1  watermark; 0 disables the watermark term.
- `ovf_o`  out  1  sticky overrun.
- `ovf_clr_i`  in  1  clear overrun.
- `tout_o`  out  1  sticky idle timeout.
- `irq_o`  out  1  interrupt.

## Operation

Frame FSM:
- States are `ST_IDLE` and `ST_FRAME`.
- `ST_IDLE` → `ST_FRAME` when `rx_sbit_i`=1. The bit counter and cycle counter clear on entry.
- In `ST_FRAME`, the cycle counter counts to `clks_per_bit_o`-1, then wraps and increments the bit counter.
- `ST_FRAME` → `ST_IDLE` on `rx_dv_i`, or when the bit counter reaches 10 (guard for false starts).

Divisor:
- `div_we_i` loads the pending register. Values below 4 are clamped to 4.
- A pending divisor is applied on any cycle the FSM is in `ST_IDLE` and `rx_sbit_i`=0.
- A later write before apply overwrites the earlier one (last write wins).

FIFO:
- Push when `rx_dv_i & en_i`.
- Pop when `rd_i & rd_valid_o`; `rd_i` on empty is ignored.
- Full plus push without pop: byte dropped, `ovf_o` set.
- Full plus push plus pop: both accepted, level unchanged.
- `flush_i` wins over push/pop in the same cycle.
- `ovf_o` clears on `ovf_clr_i`. If an overrun and a clear coincide, set wins.

Timeout (when compiled in):
- Bit-time counter runs while the FIFO is non-empty and the FSM is in `ST_IDLE`.
- The counter clears on push, pop or flush.
- Reaching `TOUT_BITS` sets `tout_o`; the counter holds.
- `tout_o` clears on pop or flush.

Interrupt:
- `irq_o` is registered: `(wm_i!=0 & level_o>=wm_i) | ovf_o | tout_o`.

## Timing

- Reset values: `clks_per_bit_o`=`RESET_DIV`, `level_o`=0, `rd_valid_o`=0, `ovf_o`=0, `tout_o`=0, `irq_o`=0, FSM in `ST_IDLE`, no pending divisor. `rd_data_o` is don't-care while empty.
- Push edge → `level_o`/`rd_valid_o` update in the same cycle (registered, visible next cycle). `rd_data_o` shows the byte one cycle after `rx_dv_i`.
- `rd_data_o` is combinational from the head pointer. A pop advances the head at the edge.
- `irq_o` lags its sources by one cycle.
- Divisor apply: `clks_per_bit_o` changes at the edge of the qualifying idle cycle. Latency from `div_we_i` is 1 cycle when idle; otherwise 1 cycle after the FSM returns to `ST_IDLE`.
- Reset mid-frame returns everything to reset values. A pending divisor is lost.

## Configuration

- `UART_RX_TIMEOUT_EN` defined: timeout counter and `tout_o` logic present.
- Not defined: counter absent, `tout_o` tied 0, `irq_o` excludes timeout.
- All other behaviour is identical in both builds.

## Structure

- Package `uart_rx_ctrl_pkg`:
  - frame-state enum `rx_frame_e` (`ST_IDLE`, `ST_FRAME`)
  - `FRAME_BITS`=10
  - `MIN_DIV`=4
- Sub-module `uart_rx_fifo`: FWFT storage, pointers, level, full/empty.
- Divisor, FSM, timeout and irq logic stay in `uart_rx_ctrl`.

## Test plan

- Divisor apply: after reset, `div_we_i` with 0x0010 while idle → `clks_per_bit_o`=0x0010 next cycle. Write 0x0002 → 0x0004.
- Deferred apply: assert `rx_sbit_i`, write 0x0020 mid-frame → `clks_per_bit_o` unchanged until the cycle after `rx_dv_i`, then 0x0020.
- Overrun: `DEPTH`=16, push 17 bytes 0x00..0x10 without reads → `level_o`=16, `ovf_o`=1, `irq_o`=1. Reading gives 0x00..0x0F; 0x10 is absent.
- Simultaneous push/pop on a full FIFO → `level_o` stays 16, `ovf_o` stays 0.
- Watermark and flush: `wm_i`=4, push 4 bytes → `irq_o`=1 one cycle after the 4th push. `flush_i` → `level_o`=0, `irq_o`=0.
- Timeout (macro on): divisor 8, `TOUT_BITS`=32, push 1 byte, no reads → `tout_o`=1 after 256 idle cycles. A pop clears it. With the macro off, `tout_o` stays 0.
